// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with a
// start/busy/done handshake; results are published atomically at the end of a conversion.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Start,
  input  logic [WIDTH-1:0]      BinaryIn,
  output logic                  Busy,
  output logic                  Done,
  output logic [4*DIGITS-1:0]   BCDOut,
  output logic                  Overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic             sticky_q, sticky_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BW-1:0]    adj_s;
  logic [BW-1:0]    step_scratch_s;
  logic             step_carry_s;

  function automatic logic [3:0] dabble_adj(input logic [3:0] digit);
    return (digit >= 4'd5) ? (digit + 4'd3) : digit;
  endfunction

  // One double-dabble step: per-digit add-3 on pre-shift values, then shift in shiftreg MSB.
  always_comb begin
    adj_s = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      adj_s[4*k +: 4] = dabble_adj(scratch_q[4*k +: 4]);
    end
    {step_carry_s, step_scratch_s} = {adj_s, shift_q[WIDTH-1]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = SHIFT;
          shift_d   = BinaryIn;
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = CNT_LOAD;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        scratch_d = step_scratch_s;
        sticky_d  = sticky_q | step_carry_s;
        cnt_d     = cnt_q - CNT_ONE;
        // The last step's carry must reach Overflow in the same edge as the final digits.
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
          bcd_d   = step_scratch_s;
          ovf_d   = sticky_q | step_carry_s;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (Start) begin
          state_d   = SHIFT;
          shift_d   = BinaryIn;
          scratch_d = '0;
          sticky_d  = 1'b0;
          cnt_d     = CNT_LOAD;
        end else begin
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      sticky_q  <= 1'b0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign BCDOut   = bcd_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 4-digit and a 3-digit instance run in lockstep
// on shared inputs, with hand-computed expected results.
module tb_bin_to_bcd_seq;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        Start;
  logic [9:0]  BinaryIn;

  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  bin_to_bcd_seq #(.WIDTH(10), .DIGITS(4)) u_dut4 (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .BinaryIn(BinaryIn),
    .Busy(busy4), .Done(done4), .BCDOut(bcd4), .Overflow(ovf4)
  );

  bin_to_bcd_seq #(.WIDTH(10), .DIGITS(3)) u_dut3 (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .BinaryIn(BinaryIn),
    .Busy(busy3), .Done(done3), .BCDOut(bcd3), .Overflow(ovf3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one conversion; glitch>0 pulses Start with 7 during that busy cycle.
  task automatic convert(input string tag, input logic [9:0] val,
                         input logic [15:0] e4, input logic eo4,
                         input logic [11:0] e3, input logic eo3, input int glitch);
    int          busy_cnt;
    logic        seen;
    logic        held_ok;
    logic [15:0] prev4;
    logic [11:0] prev3;
    prev4    = bcd4;
    prev3    = bcd3;
    held_ok  = 1'b1;
    seen     = 1'b0;
    busy_cnt = 0;
    Start    = 1'b1;
    BinaryIn = val;
    @(negedge Clock);
    Start    = 1'b0;
    BinaryIn = ~val;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done4) begin
        seen = 1'b1;
      end else begin
        if (busy4) busy_cnt++;
        if (bcd4 !== prev4 || bcd3 !== prev3) held_ok = 1'b0;
        if (glitch != 0 && busy_cnt == glitch) begin
          Start    = 1'b1;
          BinaryIn = 10'd7;
        end else begin
          Start    = 1'b0;
        end
        @(negedge Clock);
      end
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd10);
    chk({tag, " held_during_busy"}, 32'(held_ok), 32'd1);
    chk({tag, " bcd4"}, 32'(bcd4), 32'(e4));
    chk({tag, " ovf4"}, 32'(ovf4), 32'(eo4));
    chk({tag, " bcd3"}, 32'(bcd3), 32'(e3));
    chk({tag, " ovf3"}, 32'(ovf3), 32'(eo3));
    chk({tag, " done3"}, 32'(done3), 32'd1);
    chk({tag, " busy_in_done"}, 32'(busy4), 32'd0);
    @(negedge Clock);
    chk({tag, " done_single"}, 32'(done4), 32'd0);
    chk({tag, " idle_after"}, 32'(busy4), 32'd0);
  endtask

  initial begin
    int   n;
    logic seen;
    ResetN   = 1'b0;
    Start    = 1'b0;
    BinaryIn = 10'd0;
    @(negedge Clock);
    chk("rst busy", 32'(busy4), 32'd0);
    chk("rst done", 32'(done4), 32'd0);
    chk("rst bcd", 32'(bcd4), 32'd0);
    chk("rst ovf", 32'(ovf4), 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    @(negedge Clock);

    convert("zero",   10'd0,    16'h0000, 1'b0, 12'h000, 1'b0, 0);
    convert("v1023",  10'd1023, 16'h1023, 1'b0, 12'h023, 1'b1, 0);
    convert("v999",   10'd999,  16'h0999, 1'b0, 12'h999, 1'b0, 0);
    convert("v5",     10'd5,    16'h0005, 1'b0, 12'h005, 1'b0, 0);
    convert("glitch", 10'd512,  16'h0512, 1'b0, 12'h512, 1'b0, 4);

    // Start held high: a new value is accepted at every DONE edge.
    Start    = 1'b1;
    BinaryIn = 10'd100;
    for (int r = 0; r < 4; r++) begin
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge Clock);
        n++;
        if (done4) seen = 1'b1;
      end
      chk("held done_seen", 32'(seen), 32'd1);
      chk("held period", 32'(n), 32'd11);
      chk("held bcd4", 32'(bcd4), (r % 2 == 0) ? 32'h0100 : 32'h0250);
      BinaryIn = (r % 2 == 0) ? 10'd250 : 10'd100;
      if (r == 3) Start = 1'b0;
    end
    @(negedge Clock);
    chk("held stop busy", 32'(busy4), 32'd0);

    // Reset after five shifts of 777.
    Start    = 1'b1;
    BinaryIn = 10'd777;
    @(negedge Clock);
    Start = 1'b0;
    repeat (5) @(negedge Clock);
    chk("midrst busy_before", 32'(busy4), 32'd1);
    ResetN = 1'b0;
    @(negedge Clock);
    chk("midrst busy", 32'(busy4), 32'd0);
    chk("midrst done", 32'(done4), 32'd0);
    chk("midrst bcd4", 32'(bcd4), 32'd0);
    chk("midrst ovf4", 32'(ovf4), 32'd0);
    chk("midrst bcd3", 32'(bcd3), 32'd0);
    ResetN = 1'b1;
    seen   = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge Clock);
      if (done4 || busy4) seen = 1'b1;
    end
    chk("midrst quiet", 32'(seen), 32'd0);
    convert("v777",   10'd777,  16'h0777, 1'b0, 12'h777, 1'b0, 0);

    convert("v1000",  10'd1000, 16'h1000, 1'b0, 12'h000, 1'b1, 0);
    convert("v999b",  10'd999,  16'h0999, 1'b0, 12'h999, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
